// File: rtl/jtag_dma_bus_master_if.sv
// System-bus signal bundle between the JTAG DMA bus master and the bus fabric.
// The master modport is used by jtag_dma_bus_master; the slave modport is for the bus side.
interface jtag_dma_bus_master_if;
   logic        request;
   logic        granted;
   logic        beginTransaction_out;
   logic [31:0] address_data_out;
   logic [3:0]  byteEnables_out;
   logic [7:0]  burstSize_out;
   logic        readNotWrite_out;
   logic        dataValid_out;
   logic        endTransaction_out;
   logic        busy_in;
   logic [31:0] address_data_in;
   logic        dataValid_in;
   logic        endTransaction_in;
   logic        busError_in;

   modport master (
      output request, beginTransaction_out, address_data_out, byteEnables_out,
             burstSize_out, readNotWrite_out, dataValid_out, endTransaction_out,
      input  granted, busy_in, address_data_in, dataValid_in, endTransaction_in,
             busError_in
   );

   modport slave (
      input  request, beginTransaction_out, address_data_out, byteEnables_out,
             burstSize_out, readNotWrite_out, dataValid_out, endTransaction_out,
      output granted, busy_in, address_data_in, dataValid_in, endTransaction_in,
             busError_in
   );
endinterface

// File: rtl/jtag_dma_bus_master.sv
// System-clock-side JTAG chain-1 DMA engine: moves bursts between the ping-pong
// buffer port and the system bus, and reports when the buffer halves may be swapped.
module jtag_dma_bus_master #(
   parameter int MAX_BURST = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dma_address,
   input  logic [3:0]  dma_byte_enable,
   input  logic [7:0]  dma_burst_size,
   input  logic        dma_data_ready,
   input  logic        dma_readReady,
   output logic        switch_ready,
   output logic        dma_error,
   output logic [8:0]  pp_address,
   output logic        pp_writeEnable,
   output logic [31:0] pp_dataIn,
   input  logic [31:0] pp_dataOut,
   jtag_dma_bus_master_if.master bus
);
   localparam int CW = $clog2(MAX_BURST);

   typedef enum logic [3:0] {
      IDLE, W_REQ, W_BEGIN, W_FETCH, W_DATA, W_END, R_REQ, R_BEGIN, R_DATA
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          fetched_q, fetched_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [7:0]    bsize_q, bsize_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          last;

   assign last         = (cnt_q == bsize_q[CW-1:0]);
   assign switch_ready = (state_q == IDLE);
   assign dma_error    = err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         fetched_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         fetched_q <= fetched_d;
      end
   end

   always_ff @(posedge clock) begin
      addr_q  <= addr_d;
      be_q    <= be_d;
      bsize_q <= bsize_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      addr_d    = addr_q;
      be_d      = be_q;
      bsize_d   = bsize_q;
      wdata_d   = wdata_q;
      // Buffer read data is only fresh in the first W_DATA cycle after a fetch.
      fetched_d = (state_q == W_FETCH);

      pp_address               = '0;
      pp_writeEnable           = 1'b0;
      pp_dataIn                = '0;
      bus.request              = (state_q != IDLE);
      bus.beginTransaction_out = 1'b0;
      bus.address_data_out     = '0;
      bus.byteEnables_out      = '0;
      bus.burstSize_out        = '0;
      bus.readNotWrite_out     = 1'b0;
      bus.dataValid_out        = 1'b0;
      bus.endTransaction_out   = 1'b0;

      case (state_q)
         IDLE: begin
            if (dma_data_ready || dma_readReady) begin
               addr_d  = dma_address;
               be_d    = dma_byte_enable;
               bsize_d = dma_burst_size;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = dma_data_ready ? W_REQ : R_REQ;
            end
         end
         W_REQ: if (bus.granted) state_d = W_BEGIN;
         R_REQ: if (bus.granted) state_d = R_BEGIN;
         W_BEGIN, R_BEGIN: begin
            bus.beginTransaction_out = 1'b1;
            bus.address_data_out     = addr_q;
            bus.byteEnables_out      = be_q;
            bus.burstSize_out        = bsize_q;
            bus.readNotWrite_out     = (state_q == R_BEGIN);
            state_d                  = (state_q == R_BEGIN) ? R_DATA : W_FETCH;
         end
         W_FETCH: begin
            pp_address = {{(9-CW){1'b0}}, cnt_q};
            state_d    = W_DATA;
         end
         W_DATA: begin
            wdata_d              = fetched_q ? pp_dataOut : wdata_q;
            bus.dataValid_out    = 1'b1;
            bus.address_data_out = wdata_d;
            if (!bus.busy_in) begin
               if (last) begin
                  state_d = W_END;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = W_FETCH;
               end
            end
         end
         W_END: begin
            bus.endTransaction_out = 1'b1;
            state_d                = IDLE;
         end
         R_DATA: begin
            if (bus.dataValid_in) begin
               pp_writeEnable = 1'b1;
               pp_address     = {{(9-CW){1'b0}}, cnt_q};
               pp_dataIn      = bus.address_data_in;
               if (last) state_d = IDLE;
               else      cnt_d   = cnt_q + 1'b1;
            end
            if (bus.endTransaction_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A bus error aborts any burst without an end-of-transaction cycle.
      if (state_q != IDLE && bus.busError_in) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end
endmodule

// File: doc/jtag_dma_bus_master.md
Name: jtag_dma_bus_master

Overview:
- System-clock-side responder for the JTAG chain-1 command interface.
- Accepts single-cycle write/read launch commands (address, byte enable, burst size) and moves data between its port of the ping-pong buffer and the system bus as a burst bus master.
- Raises switch_ready whenever the chain may swap ping-pong halves.
- Command inputs arrive already synchronised to clock; the CDC stage sits upstream.

Parameters:
- MAX_BURST, 256, maximum words per burst; burst_size input is words-1, 8 bits.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- dma_address, input, 32, bus start address; sampled on launch.
- dma_byte_enable, input, 4, byte enables; sampled on launch.
- dma_burst_size, input, 8, words-1; sampled on launch.
- dma_data_ready, input, 1, one-cycle pulse: launch a write burst (buffer -> bus).
- dma_readReady, input, 1, one-cycle pulse: launch a read burst (bus -> buffer).
- switch_ready, output, 1, high only in IDLE.
- dma_error, output, 1, sticky bus-error flag; cleared by next launch.
- pp_address, output, 9, buffer word address (bit 8 always 0).
- pp_writeEnable, output, 1, buffer write strobe.
- pp_dataIn, output, 32, buffer write data.
- pp_dataOut, input, 32, buffer read data; 1-cycle read latency.
- request, output, 1, bus request.
- granted, input, 1, bus grant.
- beginTransaction_out, output, 1, one-cycle transaction start.
- address_data_out, output, 32, address during begin, write data during data phase, else 0.
- byteEnables_out, output, 4, valid during begin.
- burstSize_out, output, 8, valid during begin.
- readNotWrite_out, output, 1, valid during begin.
- dataValid_out, output, 1, write-data valid.
- endTransaction_out, output, 1, one-cycle end of write burst.
- busy_in, input, 1, slave stall.
- address_data_in, input, 32, read data.
- dataValid_in, input, 1, read data valid.
- endTransaction_in, input, 1, slave ends read burst.
- busError_in, input, 1, bus error.

Behaviour:
- Reset: state IDLE. switch_ready=1. All other outputs 0. Counters 0. dma_error=0.
- Launch latch: in IDLE, a launch pulse latches address/byte_enable/burst_size, clears word counter and dma_error.
  - dma_data_ready -> W_REQ; dma_readReady -> R_REQ.
  - Both in the same cycle: write wins; read is dropped.
  - Launches outside IDLE are ignored.
- States: IDLE, W_REQ, W_BEGIN, W_FETCH, W_DATA, W_END, R_REQ, R_BEGIN, R_DATA.
- W_REQ / R_REQ: request=1 until granted. Then go to W_BEGIN / R_BEGIN. request stays high through the burst and drops on the return to IDLE.
- BEGIN (1 cycle):
  - beginTransaction_out=1, address_data_out=latched address, byteEnables_out, burstSize_out=burst_size, readNotWrite_out (0 write, 1 read).
- Write path:
  - W_FETCH: pp_address=word counter, pp_writeEnable=0; next cycle go to W_DATA.
  - W_DATA: dataValid_out=1, address_data_out=pp_dataOut held in an output register.
  - If busy_in=1: hold data and dataValid_out; counter frozen.
  - If busy_in=0 and counter==burst_size: go to W_END.
  - Otherwise: counter+1, go to W_FETCH. Throughput is 1 word per 2 cycles.
  - W_END: endTransaction_out=1 for 1 cycle, then IDLE.
- Read path (R_DATA):
  - Each dataValid_in=1: pp_writeEnable=1, pp_address=counter, pp_dataIn=address_data_in, counter+1.
  - Go to IDLE when the word with counter==burst_size is written, or on endTransaction_in (short burst accepted).
  - A word arriving with endTransaction_in is still written.
- busError_in in any non-IDLE state: set dma_error, drop request, go to IDLE in the next cycle. No endTransaction_out is issued.
- Counter is 8 bits and never wraps: burst_size=255 gives 256 words at addresses 0..255.
- switch_ready is combinational on state==IDLE; deasserts in the cycle after launch.
- Reset mid-burst: immediate return to reset values. The bus is released asynchronously.

Test Plan:
- Write, burst_size=3, addr 0x0000_1000, BE=0xF, buffer preloaded 0xA0..0xA3, no busy -> begin carries 0x1000/size 3/RnW=0. Bus sees 4 dataValid words 0xA0..0xA3 in order. One endTransaction_out. switch_ready returns high.
- Write, busy_in high 3 cycles on word 1 -> word 1 held stable 3 extra cycles. No word skipped or duplicated.
- Read, burst_size=2, slave returns 0x11,0x22,0x33 with a one-cycle gap -> buffer addresses 0,1,2 hold 0x11,0x22,0x33. IDLE one cycle after the last word.
- Read, burst_size=7, endTransaction_in on 3rd word -> 3 words written, IDLE, dma_error=0.
- busError_in during W_DATA -> dma_error=1, request=0 next cycle, IDLE. Next launch clears dma_error.
- Simultaneous dma_data_ready and dma_readReady in IDLE -> write burst only. Launch pulse while busy has no effect. Reset asserted mid-read -> all outputs 0, switch_ready=1.
